// File: rtl/pwl_sum_n_if.sv
// Scale-configuration channel for pwl_sum_n: valid/ready write handshake.
// cfg_last marks the final write of a batch and triggers a commit.
`timescale 1ns/1ps
interface pwl_sum_n_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_ch;
  real        cfg_scale;
  logic       cfg_last;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_scale,
    output cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_scale,
    input  cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/pwl_sum_n.sv
// Registered weighted sum of N_CH piecewise-linear waveforms (a + b*(t - t0)) with
// double-buffered per-channel scales. Define PWL_SUM_CLAMP_EN to clamp out_a to [OUT_MIN, OUT_MAX].
`timescale 1ns/1ps
module pwl_sum_n #(
  parameter int  N_CH       = 2,
  parameter real SCALE_INIT = 1.0,
  parameter real OUT_MAX    = 1.0e3,
  parameter real OUT_MIN    = -1.0e3
) (
  input  logic            clk,
  input  logic            rstb,
  input  real             in_a_i  [N_CH],
  input  real             in_b_i  [N_CH],
  input  real             in_t0_i [N_CH],
  input  logic [N_CH-1:0] ch_en_i,
  pwl_sum_n_if.slave      cfg,
  output real             out_a_o,
  output real             out_b_o,
  output real             out_t0_o,
  output logic            out_vld_o,
  output logic            clamp_hit_o
);
  // Simulation time is in ns; waveform t0 and slopes are expressed in seconds.
  localparam real TIME_UNIT_S = 1.0e-9;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t state_q, state_d;
  logic   ready_q, ready_d;
  logic   wr_acc;
  logic   commit;
  real    scale_sh_q  [N_CH];
  real    scale_act_q [N_CH];
  real    out_a_q, out_b_q, out_t0_q;
  logic   vld_q;

  assign wr_acc        = cfg.cfg_valid & ready_q;
  assign commit        = (state_q == COMMIT);
  assign cfg.cfg_ready = ready_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (wr_acc) state_d = cfg.cfg_last ? COMMIT : LOAD;
      LOAD:    if (wr_acc && cfg.cfg_last) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != COMMIT);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // Out-of-range channel indices match no bank entry, so such writes are dropped.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_scale
    always_ff @(posedge clk) begin
      if (!rstb) begin
        scale_sh_q[gi]  <= SCALE_INIT;
        scale_act_q[gi] <= SCALE_INIT;
      end else begin
        if (wr_acc && (cfg.cfg_ch == 4'(gi))) scale_sh_q[gi] <= cfg.cfg_scale;
        if (commit) scale_act_q[gi] <= scale_sh_q[gi];
      end
    end
  end

  function automatic real now_s();
    return $realtime * TIME_UNIT_S;
  endfunction

  function automatic real sum_a(input real t);
    real acc;
    acc = 0.0;
    for (int i = 0; i < N_CH; i++)
      if (ch_en_i[i]) acc += scale_act_q[i] * (in_a_i[i] + in_b_i[i] * (t - in_t0_i[i]));
    return acc;
  endfunction

  function automatic real sum_b();
    real acc;
    acc = 0.0;
    for (int i = 0; i < N_CH; i++)
      if (ch_en_i[i]) acc += scale_act_q[i] * in_b_i[i];
    return acc;
  endfunction

  function automatic logic out_of_range(input real a);
    return (a > OUT_MAX) || (a < OUT_MIN);
  endfunction

  function automatic real clamp(input real a);
    return (a > OUT_MAX) ? OUT_MAX : ((a < OUT_MIN) ? OUT_MIN : a);
  endfunction

`ifdef PWL_SUM_CLAMP_EN
  logic clamp_q;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      out_a_q  <= 0.0;
      out_b_q  <= 0.0;
      out_t0_q <= 0.0;
      vld_q    <= 1'b0;
      clamp_q  <= 1'b0;
    end else begin
      out_a_q  <= clamp(sum_a(now_s()));
      out_b_q  <= out_of_range(sum_a(now_s())) ? 0.0 : sum_b();
      out_t0_q <= now_s();
      vld_q    <= 1'b1;
      clamp_q  <= out_of_range(sum_a(now_s()));
    end
  end

  assign clamp_hit_o = clamp_q;
`else
  always_ff @(posedge clk) begin
    if (!rstb) begin
      out_a_q  <= 0.0;
      out_b_q  <= 0.0;
      out_t0_q <= 0.0;
      vld_q    <= 1'b0;
    end else begin
      out_a_q  <= sum_a(now_s());
      out_b_q  <= sum_b();
      out_t0_q <= now_s();
      vld_q    <= 1'b1;
    end
  end

  assign clamp_hit_o = 1'b0;
`endif

  assign out_a_o   = out_a_q;
  assign out_b_o   = out_b_q;
  assign out_t0_o  = out_t0_q;
  assign out_vld_o = vld_q;
endmodule

// File: tb/tb_pwl_sum_n.sv
// Directed + randomized bench for pwl_sum_n against a scale-bank / pending-commit reference model.
`timescale 1ns/1ps
module tb_pwl_sum_n;
  localparam int  N_CH       = 2;
  localparam real SCALE_INIT = 1.0;
  localparam real OUT_MAX    = 1.0e3;
  localparam real OUT_MIN    = -1.0e3;

  logic            clk = 1'b0;
  logic            rstb;
  real             in_a  [N_CH];
  real             in_b  [N_CH];
  real             in_t0 [N_CH];
  logic [N_CH-1:0] ch_en;
  real             out_a, out_b, out_t0;
  logic            out_vld, clamp_hit;

  pwl_sum_n_if cfg_bus ();

  pwl_sum_n #(
    .N_CH(N_CH), .SCALE_INIT(SCALE_INIT), .OUT_MAX(OUT_MAX), .OUT_MIN(OUT_MIN)
  ) dut (
    .clk(clk), .rstb(rstb),
    .in_a_i(in_a), .in_b_i(in_b), .in_t0_i(in_t0), .ch_en_i(ch_en),
    .cfg(cfg_bus),
    .out_a_o(out_a), .out_b_o(out_b), .out_t0_o(out_t0),
    .out_vld_o(out_vld), .clamp_hit_o(clamp_hit)
  );

  always #5 clk = ~clk;

  // Reference model: active/shadow scales and a commit that takes effect two edges after acceptance.
  real m_act [N_CH];
  real m_sh  [N_CH];
  real pend_scales [N_CH];
  bit  pend = 1'b0;
  int  pend_edge = 0;
  int  edge_n = 0;
  bit  m_ready = 1'b0;
  bit  m_vld = 1'b0;
  bit  e_hit = 1'b0;
  real e_a = 0.0, e_b = 0.0, e_t0 = 0.0, tnow = 0.0;
  int  n_assert = 0;
  int  n_fail = 0;

  function automatic bit close(input real x, input real y);
    real d, m;
    d = x - y;
    if (d < 0.0) d = -d;
    m = (y < 0.0) ? -y : y;
    return d <= 1.0e-9 * (1.0 + m);
  endfunction

  task automatic chk_r(input string tag, input real obs, input real exp_v);
    n_assert++;
    assert (close(obs, exp_v) === 1'b1)
    else begin
      n_fail++;
      $error("FAIL %s: observed %g expected %g", tag, obs, exp_v);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic set_cfg(input bit v, input int ch, input real s, input bit last);
    cfg_bus.cfg_valid = v;
    cfg_bus.cfg_ch    = 4'(ch);
    cfg_bus.cfg_scale = s;
    cfg_bus.cfg_last  = last;
  endtask

  task automatic step();
    bit acc;
    int idx;
    acc = cfg_bus.cfg_valid && m_ready;
    idx = int'(cfg_bus.cfg_ch);
    @(posedge clk);
    tnow = $realtime * 1.0e-9;
    edge_n++;
    if (!rstb) begin
      for (int i = 0; i < N_CH; i++) begin
        m_act[i] = SCALE_INIT;
        m_sh[i]  = SCALE_INIT;
      end
      pend = 1'b0; m_ready = 1'b0; m_vld = 1'b0; e_hit = 1'b0;
      e_a = 0.0; e_b = 0.0; e_t0 = 0.0;
    end else begin
      if (pend && edge_n >= pend_edge) begin
        m_act = pend_scales;
        pend = 1'b0;
      end
      e_a = 0.0; e_b = 0.0;
      for (int i = 0; i < N_CH; i++)
        if (ch_en[i]) begin
          e_a += m_act[i] * (in_a[i] + in_b[i] * (tnow - in_t0[i]));
          e_b += m_act[i] * in_b[i];
        end
      e_t0 = tnow;
      e_hit = 1'b0;
`ifdef PWL_SUM_CLAMP_EN
      if (e_a > OUT_MAX || e_a < OUT_MIN) begin
        e_a = (e_a > OUT_MAX) ? OUT_MAX : OUT_MIN;
        e_b = 0.0;
        e_hit = 1'b1;
      end
`endif
      m_vld = 1'b1;
      m_ready = 1'b1;
      if (acc) begin
        if (idx < N_CH) m_sh[idx] = cfg_bus.cfg_scale;
        if (cfg_bus.cfg_last) begin
          pend = 1'b1;
          pend_edge = edge_n + 2;
          pend_scales = m_sh;
          m_ready = 1'b0;
        end
      end
    end
    #1;
    $display("edge %0d rstb=%0b en=%b wr=%0b a=%g b=%g t0=%g vld=%0b rdy=%0b hit=%0b",
             edge_n, rstb, ch_en, acc, out_a, out_b, out_t0, out_vld, cfg_bus.cfg_ready, clamp_hit);
    chk_b("out_vld", out_vld, m_vld);
    chk_b("cfg_ready", cfg_bus.cfg_ready, m_ready);
    chk_r("out_a", out_a, e_a);
    chk_r("out_b", out_b, e_b);
    chk_r("out_t0", out_t0, e_t0);
    chk_b("clamp_hit", clamp_hit, e_hit);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rstb = 1'b0;
    in_a = '{1.0, 2.0}; in_b = '{0.0, 0.0}; in_t0 = '{0.0, 0.0};
    ch_en = 2'b11;
    set_cfg(1'b0, 0, 0.0, 1'b0);
    step(); step();

    // Release: first sum one edge later
    rstb = 1'b1;
    step();
    chk_b("rel_vld", out_vld, 1'b1);
    chk_r("rel_a", out_a, 3.0);
    chk_r("rel_b", out_b, 0.0);

    // Ramp sampled 1us after its t0
    ch_en = 2'b01;
    in_a[0] = 0.0; in_b[0] = 1.0e6; in_t0[0] = (tnow + 10.0e-9) - 1.0e-6;
    step();
    chk_r("ramp_a", out_a, 1.0);
    chk_r("ramp_b", out_b, 1.0e6);

    // Double-buffered scale batch
    ch_en = 2'b11;
    in_a = '{1.0, 2.0}; in_b = '{0.0, 0.0}; in_t0 = '{0.0, 0.0};
    set_cfg(1'b1, 0, 2.0, 1'b0);  step(); chk_r("pre_commit_a0", out_a, 3.0);
    set_cfg(1'b1, 1, -1.0, 1'b1); step(); chk_r("pre_commit_a1", out_a, 3.0);
    chk_b("commit_ready_low", cfg_bus.cfg_ready, 1'b0);
    set_cfg(1'b0, 0, 0.0, 1'b0);  step(); chk_r("commit_edge_a", out_a, 3.0);
    chk_b("commit_ready_back", cfg_bus.cfg_ready, 1'b1);
    step(); chk_r("post_commit_a", out_a, 0.0);

    // All channels off; out-of-range channel commit leaves scales alone
    ch_en = 2'b00;
    step(); chk_r("all_off_a", out_a, 0.0); chk_r("all_off_b", out_b, 0.0);
    set_cfg(1'b1, 5, 9.0, 1'b1); step();
    set_cfg(1'b0, 0, 0.0, 1'b0); step();
    chk_b("oor_commit_ready", cfg_bus.cfg_ready, 1'b1);
    ch_en = 2'b11;
    step(); chk_r("oor_unchanged_a", out_a, 0.0);

    // Last write to the same channel wins
    set_cfg(1'b1, 0, 4.0, 1'b0); step();
    set_cfg(1'b1, 0, 1.0, 1'b1); step();
    set_cfg(1'b0, 0, 0.0, 1'b0); step(); step();
    chk_r("last_wins_a", out_a, -1.0);

    // Reset in LOAD discards shadow writes
    set_cfg(1'b1, 0, 3.0, 1'b0); step();
    set_cfg(1'b0, 0, 0.0, 1'b0);
    rstb = 1'b0; step();
    rstb = 1'b1; step();
    chk_r("rst_load_a", out_a, 3.0);
    chk_b("rst_load_ready", cfg_bus.cfg_ready, 1'b1);

    // Sum of 5.0 (clamps only with small OUT_MAX under the macro)
    in_a = '{2.0, 3.0};
    step(); chk_r("sum5_a", out_a, 5.0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < N_CH; i++) begin
        in_a[i]  = real'(int'($urandom_range(0, 2000)) - 1000) / 100.0;
        in_b[i]  = real'(int'($urandom_range(0, 2000)) - 1000);
        in_t0[i] = real'($urandom_range(0, 2000)) * 1.0e-9;
        if ($urandom_range(0, 9) == 0) in_a[i] = ($urandom_range(0, 1) == 0) ? 1500.0 : -1500.0;
      end
      ch_en = 2'($urandom_range(0, 3));
      set_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
              real'(int'($urandom_range(0, 800)) - 400) / 100.0,
              ($urandom_range(0, 9) < 3));
      rstb = ($urandom_range(0, 19) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
